// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: write-back source select, load alignment and
// sign/zero extension, and a retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned RET_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             reg_wr_i,
  input  logic [1:0]       wb_sel_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      mem_rdata_i,
  input  logic [31:0]      pc_plus4_i,
  input  logic [4:0]       rd_addr_i,
  output logic [31:0]      WRT_DATA_o,
  output logic [4:0]       WRT_ADDR_o,
  output logic             WRT_ENA_o,
  output logic             VALID_o,
  output logic             LD_ERR_o,
  output logic [RET_W-1:0] RETIRE_CNT_o
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_f3_e;

  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        ld_err;
  logic [31:0] sel_data;
  logic        err;
  logic [31:0] next_data;

  assign off = alu_result_i[1:0];

  always_comb begin
    ld_byte = '0;
    case (off)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    ld_data = '0;
    ld_err  = 1'b0;
    case (funct3_i)
      F3_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU: ld_data = {24'h0, ld_byte};
      F3_LH: begin
        ld_data = {{16{ld_half[15]}}, ld_half};
        ld_err  = off[0];
      end
      F3_LHU: begin
        ld_data = {16'h0, ld_half};
        ld_err  = off[0];
      end
      F3_LW: begin
        ld_data = mem_rdata_i;
        ld_err  = (off != 2'd0);
      end
      default: ld_err = 1'b1;
    endcase
  end

  // Reserved select is folded into err so it suppresses the write but never
  // raises LD_ERR_o, which only reports load faults.
  always_comb begin
    sel_data = '0;
    err      = 1'b0;
    case (wb_sel_e'(wb_sel_i))
      WB_ALU:  sel_data = alu_result_i;
      WB_LOAD: begin
        sel_data = ld_data;
        err      = ld_err;
      end
      WB_PC4:  sel_data = pc_plus4_i;
      default: err = 1'b1;
    endcase
    next_data = err ? '0 : sel_data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      WRT_DATA_o   <= '0;
      WRT_ADDR_o   <= '0;
      WRT_ENA_o    <= 1'b0;
      VALID_o      <= 1'b0;
      LD_ERR_o     <= 1'b0;
      RETIRE_CNT_o <= '0;
    end else if (flush_i) begin
      WRT_DATA_o <= '0;
      WRT_ADDR_o <= '0;
      WRT_ENA_o  <= 1'b0;
      VALID_o    <= 1'b0;
      LD_ERR_o   <= 1'b0;
    end else if (!stall_i) begin
      WRT_DATA_o <= next_data;
      WRT_ADDR_o <= rd_addr_i;
      WRT_ENA_o  <= valid_i & reg_wr_i & (rd_addr_i != 5'd0) & ~err;
      VALID_o    <= valid_i;
      LD_ERR_o   <= valid_i & (wb_sel_i == WB_LOAD) & err;
      if (valid_i)
        RETIRE_CNT_o <= RETIRE_CNT_o + RET_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a reference model pushes expected outputs per edge,
// a monitor pops and compares them; scenario tasks add targeted checks.
module tb_mem_wb_stage;

  localparam int unsigned RET_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             stall_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             reg_wr_i = 1'b0;
  logic [1:0]       wb_sel_i = '0;
  logic [2:0]       funct3_i = '0;
  logic [31:0]      alu_result_i = '0;
  logic [31:0]      mem_rdata_i = '0;
  logic [31:0]      pc_plus4_i = '0;
  logic [4:0]       rd_addr_i = '0;
  logic [31:0]      WRT_DATA_o;
  logic [4:0]       WRT_ADDR_o;
  logic             WRT_ENA_o;
  logic             VALID_o;
  logic             LD_ERR_o;
  logic [RET_W-1:0] RETIRE_CNT_o;

  int n_checks = 0;
  int n_fail = 0;

  mem_wb_stage #(.RET_W(RET_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .reg_wr_i(reg_wr_i), .wb_sel_i(wb_sel_i),
    .funct3_i(funct3_i), .alu_result_i(alu_result_i), .mem_rdata_i(mem_rdata_i),
    .pc_plus4_i(pc_plus4_i), .rd_addr_i(rd_addr_i), .WRT_DATA_o(WRT_DATA_o),
    .WRT_ADDR_o(WRT_ADDR_o), .WRT_ENA_o(WRT_ENA_o), .VALID_o(VALID_o),
    .LD_ERR_o(LD_ERR_o), .RETIRE_CNT_o(RETIRE_CNT_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0]      data;
    logic [4:0]       addr;
    logic             ena;
    logic             valid;
    logic             lderr;
    logic [RET_W-1:0] cnt;
  } exp_t;

  exp_t m = '0;
  exp_t sb[$];

  // Monitor: one expected entry per rising edge driven by a scenario task.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (WRT_DATA_o !== e.data) begin
        n_fail++; $display("FAIL sb_data: got %h expected %h at %0t", WRT_DATA_o, e.data, $time);
      end
      n_checks++;
      if (WRT_ADDR_o !== e.addr) begin
        n_fail++; $display("FAIL sb_addr: got %0d expected %0d at %0t", WRT_ADDR_o, e.addr, $time);
      end
      n_checks++;
      if (WRT_ENA_o !== e.ena) begin
        n_fail++; $display("FAIL sb_ena: got %b expected %b at %0t", WRT_ENA_o, e.ena, $time);
      end
      n_checks++;
      if (VALID_o !== e.valid) begin
        n_fail++; $display("FAIL sb_valid: got %b expected %b at %0t", VALID_o, e.valid, $time);
      end
      n_checks++;
      if (LD_ERR_o !== e.lderr) begin
        n_fail++; $display("FAIL sb_lderr: got %b expected %b at %0t", LD_ERR_o, e.lderr, $time);
      end
      n_checks++;
      if (RETIRE_CNT_o !== e.cnt) begin
        n_fail++; $display("FAIL sb_cnt: got %0d expected %0d at %0t", RETIRE_CNT_o, e.cnt, $time);
      end
    end
  end

  task automatic model_step();
    logic [31:0] w, d;
    logic        err;
    logic [1:0]  off;
    if (!rst_i) begin
      m = '0;
    end else if (flush_i) begin
      m.data = '0; m.addr = '0; m.ena = 1'b0; m.valid = 1'b0; m.lderr = 1'b0;
    end else if (!stall_i) begin
      off = alu_result_i[1:0];
      w = mem_rdata_i >> (8 * off);
      err = 1'b0;
      d = '0;
      case (wb_sel_i)
        2'b00: d = alu_result_i;
        2'b01: begin
          case (funct3_i)
            3'b000: d = {{24{w[7]}}, w[7:0]};
            3'b100: d = {24'h0, w[7:0]};
            3'b001: begin d = {{16{w[15]}}, w[15:0]}; err = (off == 2'd1 || off == 2'd3); end
            3'b101: begin d = {16'h0, w[15:0]}; err = (off == 2'd1 || off == 2'd3); end
            3'b010: begin d = mem_rdata_i; err = (off != 2'd0); end
            default: err = 1'b1;
          endcase
        end
        2'b10: d = pc_plus4_i;
        default: err = 1'b1;
      endcase
      m.data  = err ? 32'h0 : d;
      m.addr  = rd_addr_i;
      m.ena   = valid_i && reg_wr_i && (rd_addr_i != 5'd0) && !err;
      m.valid = valid_i;
      m.lderr = valid_i && (wb_sel_i == 2'b01) && err;
      if (valid_i) m.cnt = m.cnt + 1'b1;
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic flush,
                       input logic valid, input logic reg_wr, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4,
                       input logic [4:0] rd);
    @(negedge clk_i);
    rst_i = rst; stall_i = stall; flush_i = flush; valid_i = valid;
    reg_wr_i = reg_wr; wb_sel_i = sel; funct3_i = f3; alu_result_i = alu;
    mem_rdata_i = mem; pc_plus4_i = pc4; rd_addr_i = rd;
    model_step();
    sb.push_back(m);
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 1, 1, 2'b00, 3'b000, 32'h0000_DEAD, 32'h0, 32'h0, 5'd3);
    drive(0, 1, 1, 1, 1, 2'b00, 3'b000, 32'h0000_DEAD, 32'h0, 32'h0, 5'd3);
    n_checks++;
    if ({WRT_DATA_o, WRT_ADDR_o, WRT_ENA_o, VALID_o, LD_ERR_o, RETIRE_CNT_o} !== '0) begin
      n_fail++; $display("FAIL reset_state: data=%h addr=%0d ena=%b valid=%b err=%b cnt=%0d, all required 0",
                         WRT_DATA_o, WRT_ADDR_o, WRT_ENA_o, VALID_o, LD_ERR_o, RETIRE_CNT_o);
    end
    drive(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'h0000_DEAD, 32'h0, 32'h0, 5'd3);
    n_checks++;
    if (WRT_DATA_o !== 32'h0000_DEAD || RETIRE_CNT_o !== 4'd1) begin
      n_fail++; $display("FAIL reset_release: data=%h cnt=%0d required 0000dead and 1", WRT_DATA_o, RETIRE_CNT_o);
    end
  endtask

  task automatic test_byte_load();
    drive(1, 0, 0, 1, 1, 2'b01, 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'h0, 5'd5);
    n_checks++;
    if (WRT_DATA_o !== 32'hFFFF_FF80 || WRT_ADDR_o !== 5'd5 || WRT_ENA_o !== 1'b1) begin
      n_fail++; $display("FAIL lb: data=%h addr=%0d ena=%b required ffffff80 5 1", WRT_DATA_o, WRT_ADDR_o, WRT_ENA_o);
    end
    drive(1, 0, 0, 1, 1, 2'b01, 3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0, 5'd5);
    n_checks++;
    if (WRT_DATA_o !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu: data=%h required 00000080", WRT_DATA_o);
    end
    drive(1, 0, 0, 1, 1, 2'b01, 3'b000, 32'h0000_1001, 32'h80FF_1234, 32'h0, 5'd6);
  endtask

  task automatic test_half_misaligned();
    drive(1, 0, 0, 1, 1, 2'b01, 3'b101, 32'h0000_2002, 32'hBEEF_0001, 32'h0, 5'd9);
    n_checks++;
    if (WRT_DATA_o !== 32'h0000_BEEF || LD_ERR_o !== 1'b0) begin
      n_fail++; $display("FAIL lhu: data=%h err=%b required 0000beef 0", WRT_DATA_o, LD_ERR_o);
    end
    drive(1, 0, 0, 1, 1, 2'b01, 3'b001, 32'h0000_2003, 32'hBEEF_0001, 32'h0, 5'd9);
    n_checks++;
    if (LD_ERR_o !== 1'b1 || WRT_ENA_o !== 1'b0 || WRT_DATA_o !== 32'h0 || VALID_o !== 1'b1) begin
      n_fail++; $display("FAIL lh_misaligned: err=%b ena=%b data=%h valid=%b required 1 0 0 1",
                         LD_ERR_o, WRT_ENA_o, WRT_DATA_o, VALID_o);
    end
    drive(1, 0, 0, 1, 1, 2'b01, 3'b010, 32'h0000_2001, 32'h1234_5678, 32'h0, 5'd9);
    n_checks++;
    if (LD_ERR_o !== 1'b1) begin
      n_fail++; $display("FAIL lw_misaligned: err=%b required 1", LD_ERR_o);
    end
    drive(1, 0, 0, 1, 1, 2'b01, 3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'h0, 5'd10);
    drive(1, 0, 0, 1, 1, 2'b01, 3'b010, 32'h0000_2000, 32'h1234_5678, 32'h0, 5'd11);
    drive(1, 0, 0, 1, 1, 2'b01, 3'b110, 32'h0000_2000, 32'h1234_5678, 32'h0, 5'd11);
    n_checks++;
    if (LD_ERR_o !== 1'b1 || WRT_ENA_o !== 1'b0) begin
      n_fail++; $display("FAIL illegal_funct3: err=%b ena=%b required 1 0", LD_ERR_o, WRT_ENA_o);
    end
    drive(1, 0, 0, 1, 1, 2'b11, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd12);
    n_checks++;
    if (LD_ERR_o !== 1'b0 || WRT_ENA_o !== 1'b0 || WRT_DATA_o !== 32'h0) begin
      n_fail++; $display("FAIL wb_reserved: err=%b ena=%b data=%h required 0 0 0", LD_ERR_o, WRT_ENA_o, WRT_DATA_o);
    end
  endtask

  task automatic test_wb_select();
    logic [RET_W-1:0] c;
    drive(1, 0, 0, 1, 1, 2'b10, 3'b000, 32'h0000_0055, 32'h0, 32'h0000_0108, 5'd1);
    n_checks++;
    if (WRT_DATA_o !== 32'h0000_0108 || WRT_ENA_o !== 1'b1) begin
      n_fail++; $display("FAIL pc4_rd1: data=%h ena=%b required 00000108 1", WRT_DATA_o, WRT_ENA_o);
    end
    c = m.cnt;
    drive(1, 0, 0, 1, 1, 2'b10, 3'b000, 32'h0000_0055, 32'h0, 32'h0000_0108, 5'd0);
    n_checks++;
    if (WRT_ENA_o !== 1'b0 || WRT_DATA_o !== 32'h0000_0108 || RETIRE_CNT_o !== c + 1'b1) begin
      n_fail++; $display("FAIL pc4_rd0: ena=%b data=%h cnt=%0d required 0 00000108 %0d",
                         WRT_ENA_o, WRT_DATA_o, RETIRE_CNT_o, c + 1'b1);
    end
    drive(1, 0, 0, 0, 1, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h0, 5'd4);
  endtask

  task automatic test_stall_flush();
    logic [RET_W-1:0] c;
    drive(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 5'd7);
    c = m.cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 1, 2'b10, 3'b000, 32'h0000_0099 + i, 32'h0, 32'h0000_0200, 5'd8);
      n_checks++;
      if (WRT_DATA_o !== 32'h0000_0055 || WRT_ADDR_o !== 5'd7 || WRT_ENA_o !== 1'b1 || RETIRE_CNT_o !== c) begin
        n_fail++; $display("FAIL stall_hold%0d: data=%h addr=%0d ena=%b cnt=%0d required 00000055 7 1 %0d",
                           i, WRT_DATA_o, WRT_ADDR_o, WRT_ENA_o, RETIRE_CNT_o, c);
      end
    end
    drive(1, 1, 1, 1, 1, 2'b00, 3'b000, 32'h0000_0033, 32'h0, 32'h0, 5'd8);
    n_checks++;
    if (VALID_o !== 1'b0 || WRT_ENA_o !== 1'b0 || WRT_DATA_o !== 32'h0 || RETIRE_CNT_o !== c) begin
      n_fail++; $display("FAIL stall_flush: valid=%b ena=%b data=%h cnt=%0d required 0 0 0 %0d",
                         VALID_o, WRT_ENA_o, WRT_DATA_o, RETIRE_CNT_o, c);
    end
  endtask

  task automatic test_counter_wrap();
    drive(0, 0, 0, 1, 1, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd2);
    for (int i = 1; i <= 17; i++) begin
      drive(1, 0, 0, 1, i[0], 2'b00, 3'b000, 32'h0000_1000 + i, 32'h0, 32'h0, 5'(i));
      if (i >= 15) begin
        n_checks++;
        if (RETIRE_CNT_o !== 4'((i == 15) ? 15 : i - 16)) begin
          n_fail++; $display("FAIL wrap_%0d: cnt=%0d required %0d", i, RETIRE_CNT_o, (i == 15) ? 15 : i - 16);
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b0;
    test_reset();
    test_byte_load();
    test_half_misaligned();
    test_wb_select();
    test_stall_flush();
    test_counter_wrap();
    @(negedge clk_i);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
